// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU (A) and load (B) writeback.
// The winning write goes through one output register; reads that match that in-flight write are forwarded.
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_regWrite,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    wr_req_t          a_req, b_req, win_req, out_q;
    logic             prio;
    logic             out_vld;
    logic             a_hs, b_hs;
    logic             contention;
    logic [CNT_W-1:0] cnt_q;

    assign a_req = {a_reg, a_data};
    assign b_req = {b_reg, b_data};

    // Grants ignore the port's own valid so a requester can see its slot before asserting.
    assign a_ready = !stall && (!b_valid || !prio);
    assign b_ready = !stall && (!a_valid ||  prio);

    assign a_hs       = a_valid && a_ready;
    assign b_hs       = b_valid && b_ready;
    assign win_req    = a_hs ? a_req : b_req;
    assign contention = a_valid && b_valid && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio    <= 1'b0;
            out_q   <= '0;
            out_vld <= 1'b0;
            cnt_q   <= '0;
        end else begin
            out_vld <= 1'b0;
            if (a_hs || b_hs) begin
                // Register-0 writes still load the stage but never strobe the file.
                out_q   <= win_req;
                out_vld <= (win_req.rd != '0);
                prio    <= a_hs;
            end
            if (contention && (cnt_q != '1))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign rf_write_reg  = out_q.rd;
    assign rf_write_data = out_q.data;
    assign rf_regWrite   = out_vld;
    assign conflict_cnt  = cnt_q;

    assign fwd_hit1  = out_vld && (read_reg1 == out_q.rd);
    assign fwd_hit2  = out_vld && (read_reg2 == out_q.rd);
    assign fwd_data1 = fwd_hit1 ? out_q.data : '0;
    assign fwd_data2 = fwd_hit2 ? out_q.data : '0;

endmodule
